// File: rtl/simple_pkg.sv
// Shared encodings for the ALU flag interface and the branch condition field.
package simple_pkg;

    localparam int unsigned FLAG_W = 4;

    // Bit positions inside the {S,Z,C,V} flag vector
    localparam int unsigned FLAG_S = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam logic [2:0] COND_BE  = 3'b000;
    localparam logic [2:0] COND_BLT = 3'b001;
    localparam logic [2:0] COND_BLE = 3'b010;
    localparam logic [2:0] COND_BNE = 3'b011;
    localparam logic [2:0] COND_B   = 3'b100;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition resolver: {S,Z,C,V} flags plus condition code -> taken.
module branch_cond_eval
    import simple_pkg::*;
(
    input  logic [FLAG_W-1:0] flags_i,
    input  logic [2:0]        cond_i,
    output logic              taken_o
);

    logic s_xor_v;
    logic unused_carry;

    assign s_xor_v      = flags_i[FLAG_S] ^ flags_i[FLAG_V];
    // Carry is never part of a branch condition
    assign unused_carry = flags_i[FLAG_C];

    always_comb begin
        taken_o = 1'b0;
        case (cond_i)
            COND_BE:  taken_o = flags_i[FLAG_Z];
            COND_BLT: taken_o = s_xor_v;
            COND_BLE: taken_o = flags_i[FLAG_Z] | s_xor_v;
            COND_BNE: taken_o = ~flags_i[FLAG_Z];
            COND_B:   taken_o = 1'b1;
            default:  taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// Execute-stage flag register and branch resolver; issues a registered redirect
// to fetch and squashes wrong-path flag writes and branches after a taken branch.
module flag_branch_unit
    import simple_pkg::*;
#(
    parameter int unsigned SQUASH_CYCLES = 2,
    parameter int unsigned PC_W          = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [FLAG_W-1:0] FLAG_OUT,
    input  logic              FLAG_WRITE,
    input  logic              EX_VALID,
    input  logic              STALL,
    input  logic              FLUSH,
    input  logic              BR_VALID,
    output logic              BR_READY,
    input  logic [2:0]        BR_COND,
    input  logic [PC_W-1:0]   BR_PC,
    input  logic [PC_W-1:0]   BR_DISP,
    output logic              REDIRECT,
    output logic [PC_W-1:0]   REDIRECT_PC,
    output logic [FLAG_W-1:0] FLAGS,
    output logic              SQUASHING
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_SQUASH = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              redirect_q, redirect_d;
    logic [PC_W-1:0]   redirect_pc_q, redirect_pc_d;

    logic              flag_wr;
    logic [FLAG_W-1:0] eff_flags;
    logic              cond_taken;
    logic              accept;
    logic              taken;

    assign flag_wr   = EX_VALID & FLAG_WRITE;
    // The same-cycle ALU op is older than the branch, so its flags must be bypassed
    assign eff_flags = flag_wr ? FLAG_OUT : flags_q;

    branch_cond_eval u_cond (
        .flags_i (eff_flags),
        .cond_i  (BR_COND),
        .taken_o (cond_taken)
    );

    assign BR_READY = (state_q == ST_IDLE) & ~STALL & ~FLUSH & ~RST;
    assign accept   = BR_VALID & BR_READY;
    assign taken    = accept & cond_taken;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        flags_d       = flags_q;
        redirect_d    = taken;
        redirect_pc_d = redirect_pc_q;

        if (taken) begin
            redirect_pc_d = BR_PC + PC_W'(1) + BR_DISP;
        end

        if ((state_q == ST_IDLE) && !STALL && flag_wr) begin
            flags_d = FLAG_OUT;
        end

        if (FLUSH) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (taken) begin
                        state_d = ST_SQUASH;
                        cnt_d   = 4'(SQUASH_CYCLES);
                    end
                end
                ST_SQUASH: begin
                    if (!STALL) begin
                        if (cnt_q == 4'd1) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            flags_q       <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            flags_q       <= flags_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign REDIRECT    = redirect_q;
    assign REDIRECT_PC = redirect_pc_q;
    assign FLAGS       = flags_q;
    assign SQUASHING   = (state_q == ST_SQUASH);

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed self-checking bench for flag_branch_unit with hand-computed expectations.
module tb_flag_branch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  flag_out;
    logic        flag_write;
    logic        ex_valid;
    logic        stall;
    logic        flush;
    logic        br_valid;
    logic        br_ready;
    logic [2:0]  br_cond;
    logic [15:0] br_pc;
    logic [15:0] br_disp;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [3:0]  flags;
    logic        squashing;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned n;

    always #5 clk = ~clk;

    flag_branch_unit #(.SQUASH_CYCLES(2), .PC_W(16)) dut (
        .CLK         (clk),
        .RST         (rst),
        .FLAG_OUT    (flag_out),
        .FLAG_WRITE  (flag_write),
        .EX_VALID    (ex_valid),
        .STALL       (stall),
        .FLUSH       (flush),
        .BR_VALID    (br_valid),
        .BR_READY    (br_ready),
        .BR_COND     (br_cond),
        .BR_PC       (br_pc),
        .BR_DISP     (br_disp),
        .REDIRECT    (redirect),
        .REDIRECT_PC (redirect_pc),
        .FLAGS       (flags),
        .SQUASHING   (squashing)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; flag_out = '0; flag_write = 0; ex_valid = 0; stall = 0; flush = 0;
        br_valid = 0; br_cond = '0; br_pc = '0; br_disp = '0;
        step(); step();
        chk("ready_in_rst", 32'(br_ready), 0);
        rst = 1'b0;
        settle();
        chk("rst_flags", 32'(flags), 0);
        chk("rst_redirect", 32'(redirect), 0);
        chk("rst_redirect_pc", 32'(redirect_pc), 0);
        chk("rst_squashing", 32'(squashing), 0);
        chk("rst_ready", 32'(br_ready), 1);

        // Flag write then BE in the following cycle
        flag_out = 4'b0100; flag_write = 1; ex_valid = 1;
        step();
        flag_write = 0; ex_valid = 0; flag_out = '0;
        chk("fw_flags", 32'(flags), 32'h4);
        br_valid = 1; br_cond = 3'b000; br_pc = 16'h0010; br_disp = 16'h0005;
        step();
        br_valid = 0;
        settle();
        chk("be_redirect", 32'(redirect), 1);
        chk("be_pc", 32'(redirect_pc), 32'h0016);
        chk("be_squashing", 32'(squashing), 1);
        chk("be_ready_sq", 32'(br_ready), 0);
        step();
        chk("be_pulse_end", 32'(redirect), 0);
        chk("be_sq2", 32'(squashing), 1);
        step();
        chk("be_idle", 32'(squashing), 0);
        chk("be_ready_idle", 32'(br_ready), 1);
        chk("be_pc_hold", 32'(redirect_pc), 32'h0016);

        // Bypass: stale FLAGS=0000, same-cycle FLAG_OUT=1000 with BLT
        rst = 1; step(); rst = 0;
        flag_out = 4'b1000; flag_write = 1; ex_valid = 1;
        br_valid = 1; br_cond = 3'b001; br_pc = 16'h0020; br_disp = 16'hFFF0;
        step();
        flag_write = 0; ex_valid = 0; br_valid = 0; flag_out = '0;
        chk("blt_redirect", 32'(redirect), 1);
        chk("blt_pc", 32'(redirect_pc), 32'h0011);
        chk("blt_flags", 32'(flags), 32'h8);
        step(); step();
        chk("blt_idle", 32'(squashing), 0);

        // Taken B, then wrong-path flag writes and branch during squash
        br_valid = 1; br_cond = 3'b100; br_pc = 16'h0100; br_disp = 16'h0000;
        step();
        chk("b_pc", 32'(redirect_pc), 32'h0101);
        flag_out = 4'b0100; flag_write = 1; ex_valid = 1;
        br_pc = 16'h0200;
        settle();
        chk("sq_ready1", 32'(br_ready), 0);
        step();
        chk("sq_flags1", 32'(flags), 32'h8);
        chk("sq_redirect1", 32'(redirect), 0);
        chk("sq_squashing2", 32'(squashing), 1);
        chk("sq_ready2", 32'(br_ready), 0);
        step();
        chk("sq_flags2", 32'(flags), 32'h8);
        chk("sq_redirect2", 32'(redirect), 0);
        chk("sq_idle3", 32'(squashing), 0);
        chk("sq_ready3", 32'(br_ready), 1);
        chk("sq_pc_hold", 32'(redirect_pc), 32'h0101);
        br_valid = 0;
        step();

        // BNE with Z=1 not taken; cond 110 never taken
        chk("z_flags", 32'(flags), 32'h4);
        flag_write = 0; ex_valid = 0; flag_out = '0;
        br_valid = 1; br_cond = 3'b011; br_pc = 16'h0030; br_disp = 16'h0004;
        step();
        chk("bne_redirect", 32'(redirect), 0);
        chk("bne_squashing", 32'(squashing), 0);
        chk("bne_ready", 32'(br_ready), 1);
        chk("bne_pc_hold", 32'(redirect_pc), 32'h0101);
        br_cond = 3'b110;
        step();
        chk("never_redirect", 32'(redirect), 0);
        chk("never_ready", 32'(br_ready), 1);
        br_cond = 3'b010;
        step();
        chk("ble_z_taken", 32'(redirect), 1);
        chk("ble_pc", 32'(redirect_pc), 32'h0035);
        br_valid = 0;
        step(); step();

        // STALL held 3 cycles inside the squash window
        br_valid = 1; br_cond = 3'b100; br_pc = 16'h0040; br_disp = 16'h0002;
        step();
        br_valid = 0;
        chk("st_redirect", 32'(redirect), 1);
        chk("st_pc", 32'(redirect_pc), 32'h0043);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (!squashing) break;
            n++;
            stall = (n <= 3);
            step();
            if (n == 1) chk("st_pulse_end", 32'(redirect), 0);
        end
        stall = 0;
        chk("st_sq_len", n, 5);
        chk("st_idle", 32'(squashing), 0);

        // FLUSH mid-squash cancels window; branch in FLUSH cycle is refused
        br_valid = 1; br_cond = 3'b100; br_pc = 16'h0050; br_disp = 16'h0000;
        step();
        chk("fl_redirect", 32'(redirect), 1);
        flush = 1;
        settle();
        chk("fl_ready_sq", 32'(br_ready), 0);
        step();
        chk("fl_redirect_clr", 32'(redirect), 0);
        chk("fl_idle", 32'(squashing), 0);
        chk("fl_ready_idle", 32'(br_ready), 0);
        chk("fl_flags", 32'(flags), 32'h4);
        step();
        chk("fl_no_accept", 32'(redirect), 0);
        flush = 0; br_valid = 0;
        settle();
        chk("fl_ready_after", 32'(br_ready), 1);

        // Address wrap, then reset in the middle of the squash window
        br_valid = 1; br_cond = 3'b100; br_pc = 16'hFFFF; br_disp = 16'h0000;
        step();
        br_valid = 0;
        chk("wrap_redirect", 32'(redirect), 1);
        chk("wrap_pc", 32'(redirect_pc), 32'h0000);
        br_pc = 16'h1234; br_valid = 1;
        step();
        br_valid = 0;
        rst = 1;
        step();
        chk("mrst_redirect", 32'(redirect), 0);
        chk("mrst_pc", 32'(redirect_pc), 0);
        chk("mrst_flags", 32'(flags), 0);
        chk("mrst_squashing", 32'(squashing), 0);
        chk("mrst_ready", 32'(br_ready), 0);
        rst = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
